flash_read_arbiter: RTL

FLASH_READ_ARBITER -- requirements
Module: flash_read_arbiter

---
 rtl/flash_read_arbiter.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/flash_read_arbiter.sv
// flash_read_arbiter
// Two-port (video / aux) read arbiter for an 8-bit parallel NOR flash.
// Each read holds FL_OE_N low for ACCESS_CYCLES clocks with a stable address,
// captures FL_DQ on the closing edge, then spends one recovery clock with
// FL_OE_N high before the next grant.
// Build option: define FLASH_ARB_RR_EN to alternate grants between the two
// ports on simultaneous requests; otherwise video has fixed priority.
module flash_read_arbiter #(
    parameter int unsigned ACCESS_CYCLES = 5
) (
    input  logic        CLOCK_50,
    input  logic        reset,

    input  logic        v_req,
    input  logic [21:0] v_addr,
    output logic        v_ack,
    output logic [7:0]  v_rdata,
    output logic        v_rvalid,

    input  logic        a_req,
    input  logic [21:0] a_addr,
    output logic        a_ack,
    output logic [7:0]  a_rdata,
    output logic        a_rvalid,

    output logic [21:0] FL_ADDR,
    inout  wire  [7:0]  FL_DQ,
    output logic        FL_OE_N,
    output logic        FL_WE_N,
    output logic        FL_RST_N,

    output logic        busy
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] ACCESS  = 2'd1;
    localparam logic [1:0] RECOVER = 2'd2;

    // Counter runs ACCESS_CYCLES-1 down to 0, giving ACCESS_CYCLES clocks in ACCESS.
    localparam logic [3:0] CNT_LOAD = 4'(ACCESS_CYCLES - 1);

    logic [1:0]  state_q,    state_d;
    logic [3:0]  cnt_q,      cnt_d;
    logic [21:0] addr_q,     addr_d;
    logic        oe_n_q,     oe_n_d;
    logic        gnt_aux_q,  gnt_aux_d;
    logic        v_ack_q,    v_ack_d;
    logic        a_ack_q,    a_ack_d;
    logic        v_rvalid_q, v_rvalid_d;
    logic        a_rvalid_q, a_rvalid_d;
    logic [7:0]  v_rdata_q,  v_rdata_d;
    logic [7:0]  a_rdata_q,  a_rdata_d;
    logic        pick_aux;

`ifdef FLASH_ARB_RR_EN
    // Round-robin pointer: high when aux holds priority for the next contested grant.
    logic        prio_aux_q, prio_aux_d;

    // Contested grants go to the port holding the pointer.
    always_comb begin
        pick_aux = a_req && (!v_req || prio_aux_q);
    end
`else
    // Video always wins a contested grant.
    always_comb begin
        pick_aux = a_req && !v_req;
    end
`endif

    // Next-state logic for the IDLE -> ACCESS -> RECOVER read cycle.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        oe_n_d     = oe_n_q;
        gnt_aux_d  = gnt_aux_q;
        v_ack_d    = 1'b0;
        a_ack_d    = 1'b0;
        v_rvalid_d = 1'b0;
        a_rvalid_d = 1'b0;
        v_rdata_d  = v_rdata_q;
        a_rdata_d  = a_rdata_q;
`ifdef FLASH_ARB_RR_EN
        prio_aux_d = prio_aux_q;
`endif

        case (state_q)
            IDLE: begin
                if (v_req || a_req) begin
                    addr_d    = pick_aux ? a_addr : v_addr;
                    oe_n_d    = 1'b0;
                    gnt_aux_d = pick_aux;
                    v_ack_d   = !pick_aux;
                    a_ack_d   = pick_aux;
                    cnt_d     = CNT_LOAD;
                    state_d   = ACCESS;
`ifdef FLASH_ARB_RR_EN
                    prio_aux_d = !pick_aux;
`endif
                end
            end

            ACCESS: begin
                if (cnt_q == 4'd0) begin
                    if (gnt_aux_q) begin
                        a_rdata_d  = FL_DQ;
                        a_rvalid_d = 1'b1;
                    end else begin
                        v_rdata_d  = FL_DQ;
                        v_rvalid_d = 1'b1;
                    end
                    oe_n_d  = 1'b1;
                    state_d = RECOVER;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end

            RECOVER: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
                oe_n_d  = 1'b1;
            end
        endcase
    end

    // State registers; reset also lifts FL_OE_N at once, aborting any read.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            addr_q     <= '0;
            oe_n_q     <= 1'b1;
            gnt_aux_q  <= 1'b0;
            v_ack_q    <= 1'b0;
            a_ack_q    <= 1'b0;
            v_rvalid_q <= 1'b0;
            a_rvalid_q <= 1'b0;
            v_rdata_q  <= '0;
            a_rdata_q  <= '0;
`ifdef FLASH_ARB_RR_EN
            prio_aux_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            oe_n_q     <= oe_n_d;
            gnt_aux_q  <= gnt_aux_d;
            v_ack_q    <= v_ack_d;
            a_ack_q    <= a_ack_d;
            v_rvalid_q <= v_rvalid_d;
            a_rvalid_q <= a_rvalid_d;
            v_rdata_q  <= v_rdata_d;
            a_rdata_q  <= a_rdata_d;
`ifdef FLASH_ARB_RR_EN
            prio_aux_q <= prio_aux_d;
`endif
        end
    end

    assign FL_DQ    = 'z;
    assign FL_ADDR  = addr_q;
    assign FL_OE_N  = oe_n_q;
    assign FL_WE_N  = 1'b1;
    assign FL_RST_N = 1'b1;

    assign v_ack    = v_ack_q;
    assign a_ack    = a_ack_q;
    assign v_rvalid = v_rvalid_q;
    assign a_rvalid = a_rvalid_q;
    assign v_rdata  = v_rdata_q;
    assign a_rdata  = a_rdata_q;

    assign busy     = (state_q != IDLE);

endmodule
